mem_port_ctrl: RTL and testbench

//  Sequencer directly upstream of the 16-bit unified instruction/data memory.

---
 rtl/mem_ctrl_pkg.sv | 11 +
 rtl/mem_rr_arb.sv | 24 ++
 rtl/mem_port_ctrl.sv | 108 ++++++++++
 tb/tb_mem_port_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared FSM encoding and grant ids for the unified-memory port sequencer.
package mem_ctrl_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_LS = 1'b1;
endpackage

// File: rtl/mem_rr_arb.sv
// Two-input fetch/load-store arbiter, combinational; alternates on conflict when FAIR,
// otherwise load/store always wins. No backpressure of its own.
module mem_rr_arb
  import mem_ctrl_pkg::*;
#(
  parameter bit FAIR = 1'b1
) (
  input  logic if_req,
  input  logic ls_req,
  input  logic last_grant,
  output logic gnt_valid,
  output logic gnt_id
);

  always_comb begin
    gnt_valid = if_req | ls_req;
    gnt_id    = GNT_IF;
    if (if_req && ls_req)
      gnt_id = FAIR ? ~last_grant : GNT_LS;
    else if (ls_req)
      gnt_id = GNT_LS;
  end

endmodule

// File: rtl/mem_port_ctrl.sv
// Single-port memory sequencer: IDLE->ACCESS->RESP, fixed 3-cycle latency, one access per 3 cycles.
// Requesters hold req until their one-cycle ack; the loser of arbitration simply waits.
module mem_port_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int AW   = 16,
  parameter int DW   = 16,
  parameter bit FAIR = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_data,
  output logic          if_err,
  input  logic          ls_req,
  input  logic          ls_we,
  input  logic [AW-1:0] ls_addr,
  input  logic [DW-1:0] ls_wdata,
  output logic          ls_ack,
  output logic [DW-1:0] ls_rdata,
  output logic          ls_err,
  output logic [AW-1:0] mem_a,
  output logic          mem_we,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
);

  state_t state;
  logic   last_grant;
  logic   lat_id;
  logic   lat_we;
  logic   gnt_valid;
  logic   gnt_id;
  logic   odd;

  mem_rr_arb #(.FAIR(FAIR)) u_arb (
    .if_req     (if_req),
    .ls_req     (ls_req),
    .last_grant (last_grant),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );

  // mem_a holds the latched address, so its bit 0 is the misalignment flag
  assign odd = mem_a[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= GNT_IF;
      lat_id     <= GNT_IF;
      lat_we     <= 1'b0;
      mem_a      <= '0;
      mem_we     <= 1'b0;
      mem_wd     <= '0;
      if_ack     <= 1'b0;
      if_err     <= 1'b0;
      if_data    <= '0;
      ls_ack     <= 1'b0;
      ls_err     <= 1'b0;
      ls_rdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            last_grant <= gnt_id;
            lat_id     <= gnt_id;
            state      <= ACCESS;
            if (gnt_id == GNT_LS) begin
              mem_a  <= ls_addr;
              mem_wd <= ls_wdata;
              lat_we <= ls_we;
              mem_we <= ls_we & ~ls_addr[0];
            end else begin
              mem_a  <= if_addr;
              lat_we <= 1'b0;
            end
          end
        end
        ACCESS: begin
          mem_we <= 1'b0;
          state  <= RESP;
          if (!lat_we) begin
            if (lat_id == GNT_IF)
              if_data <= odd ? '0 : mem_rd;
            else
              ls_rdata <= odd ? '0 : mem_rd;
          end
          if_ack <= (lat_id == GNT_IF);
          ls_ack <= (lat_id == GNT_LS);
          if_err <= (lat_id == GNT_IF) & odd;
          ls_err <= (lat_id == GNT_LS) & odd;
        end
        RESP: begin
          if_ack <= 1'b0;
          ls_ack <= 1'b0;
          if_err <= 1'b0;
          ls_err <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Bench for mem_port_ctrl: a fair instance on a behavioural memory, plus an LS-priority instance.
module tb_mem_port_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, ls_req, ls_we;
  logic [15:0] if_addr, ls_addr, ls_wdata;

  logic        if_ack, if_err, ls_ack, ls_err, mem_we;
  logic [15:0] if_data, ls_rdata, mem_a, mem_wd, mem_rd;

  logic        p_if_ack, p_if_err, p_ls_ack, p_ls_err, p_mem_we;
  logic [15:0] p_if_data, p_ls_rdata, p_mem_a, p_mem_wd;
  logic [15:0] zero_rd;

  logic [15:0] mem     [0:32767];
  logic [15:0] ref_mem [0:32767];
  logic        init_mem;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_port_ctrl #(.AW(16), .DW(16), .FAIR(1'b1)) u_dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_data(if_data), .if_err(if_err),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_ack(ls_ack), .ls_rdata(ls_rdata), .ls_err(ls_err),
    .mem_a(mem_a), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  mem_port_ctrl #(.AW(16), .DW(16), .FAIR(1'b0)) u_dut_lsprio (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(p_if_ack), .if_data(p_if_data), .if_err(p_if_err),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_ack(p_ls_ack), .ls_rdata(p_ls_rdata), .ls_err(p_ls_err),
    .mem_a(p_mem_a), .mem_we(p_mem_we), .mem_wd(p_mem_wd), .mem_rd(zero_rd)
  );

  assign zero_rd = 16'h0000;
  assign mem_rd  = mem[mem_a[15:1]];

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 32768; i++) mem[i] <= ref_mem[i];
    end else if (mem_we) begin
      mem[mem_a[15:1]] <= mem_wd;
    end
  end

  task automatic test_reset();
    reset = 1'b1; init_mem = 1'b1;
    if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
    if_addr = '0; ls_addr = '0; ls_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({if_ack, ls_ack, if_err, ls_err, mem_we} !== 5'b0) begin
      bad++; $display("FAIL reset_flags: got %b want 00000", {if_ack, ls_ack, if_err, ls_err, mem_we});
    end
    total++;
    if ({mem_a, mem_wd, if_data, ls_rdata} !== 64'h0) begin
      bad++; $display("FAIL reset_data: got %h want 0", {mem_a, mem_wd, if_data, ls_rdata});
    end
    init_mem = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // One complete request on the fair DUT; starts and ends on a falling edge.
  task automatic do_access(input bit is_ls, input bit we, input logic [15:0] addr,
                           input logic [15:0] wd, input string name);
    int          cyc, we_cnt;
    bit          got, odd, wr;
    logic [15:0] exp_d;
    odd   = addr[0];
    wr    = is_ls && we && !odd;
    exp_d = odd ? 16'h0000 : ref_mem[addr[15:1]];
    if (is_ls) begin
      ls_req = 1'b1; ls_we = we; ls_addr = addr; ls_wdata = wd;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    got = 1'b0; we_cnt = 0; cyc = 1;
    while (!got && cyc < 12) begin
      @(negedge clk);
      cyc++;
      if (mem_we) we_cnt++;
      if (cyc == 2) begin
        total++;
        if (mem_a !== addr) begin
          bad++; $display("FAIL %s mem_a: got %h want %h", name, mem_a, addr);
        end
      end
      if (if_ack || ls_ack) got = 1'b1;
    end
    if_req = 1'b0; ls_req = 1'b0;
    total++;
    if (!got) begin
      bad++; $display("FAIL %s ack_timeout: got none want ack", name);
    end else begin
      total++;
      if (cyc !== 3) begin
        bad++; $display("FAIL %s latency: got %0d want 3", name, cyc);
      end
      total++;
      if ({if_ack, ls_ack} !== (is_ls ? 2'b01 : 2'b10)) begin
        bad++; $display("FAIL %s ack_sel: got %b want %b", name, {if_ack, ls_ack}, is_ls ? 2'b01 : 2'b10);
      end
      total++;
      if ((is_ls ? ls_err : if_err) !== odd) begin
        bad++; $display("FAIL %s err: got %b want %b", name, is_ls ? ls_err : if_err, odd);
      end
      if (!(is_ls && we)) begin
        total++;
        if ((is_ls ? ls_rdata : if_data) !== exp_d) begin
          bad++; $display("FAIL %s rdata: got %h want %h", name, is_ls ? ls_rdata : if_data, exp_d);
        end
      end
    end
    total++;
    if (we_cnt !== (wr ? 1 : 0)) begin
      bad++; $display("FAIL %s we_cycles: got %0d want %0d", name, we_cnt, wr ? 1 : 0);
    end
    if (wr) ref_mem[addr[15:1]] = wd;
    @(negedge clk);
    total++;
    if (mem[addr[15:1]] !== ref_mem[addr[15:1]]) begin
      bad++; $display("FAIL %s mem_word: got %h want %h", name, mem[addr[15:1]], ref_mem[addr[15:1]]);
    end
  endtask

  task automatic test_fetch();
    do_access(1'b0, 1'b0, 16'h0000, 16'h0000, "fetch0");
  endtask

  task automatic test_store_load();
    do_access(1'b1, 1'b1, 16'h0084, 16'h0DEF, "store84");
    do_access(1'b1, 1'b0, 16'h0084, 16'h0000, "load84");
    total++;
    if (ls_rdata !== 16'h0DEF) begin
      bad++; $display("FAIL load84_value: got %h want 0def", ls_rdata);
    end
  endtask

  task automatic test_misaligned();
    do_access(1'b1, 1'b1, 16'h0085, 16'($urandom), "store85");
    do_access(1'b0, 1'b0, 16'h0003, 16'h0000, "fetch3");
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      int          op;
      logic [15:0] a;
      op = int'($urandom_range(0, 2));
      a  = 16'($urandom_range(0, 127)) << 1;
      if ($urandom_range(0, 3) == 0) a[0] = 1'b1;
      do_access(op != 0, op == 2, a, 16'($urandom), $sformatf("rnd%0d", n));
    end
  endtask

  task automatic test_back_to_back();
    int acks[$];
    int cyc;
    if_addr = 16'($urandom_range(0, 127)) << 1;
    if_req  = 1'b1;
    cyc = 0;
    while (acks.size() < 2 && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (if_ack) begin
        acks.push_back(cyc);
        total++;
        if (if_data !== ref_mem[if_addr[15:1]]) begin
          bad++; $display("FAIL b2b_data: got %h want %h", if_data, ref_mem[if_addr[15:1]]);
        end
      end
    end
    if_req = 1'b0;
    total++;
    if (acks.size() != 2) begin
      bad++; $display("FAIL b2b_acks: got %0d want 2", acks.size());
    end else begin
      total++;
      if (acks[1] - acks[0] != 3) begin
        bad++; $display("FAIL b2b_spacing: got %0d want 3", acks[1] - acks[0]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_conflict();
    bit last_ls;
    bit exp_ls;
    int n_fair, cyc;
    bit seen_if;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    last_ls = 1'b0;
    n_fair  = 0;
    cyc     = 0;
    if_addr = 16'h0010; ls_addr = 16'h0020; ls_we = 1'b0;
    if_req = 1'b1; ls_req = 1'b1;
    while (n_fair < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (if_ack || ls_ack) begin
        exp_ls = !last_ls;
        total++;
        if ({if_ack, ls_ack} !== (exp_ls ? 2'b01 : 2'b10)) begin
          bad++; $display("FAIL fair_grant%0d: got %b want %b", n_fair, {if_ack, ls_ack}, exp_ls ? 2'b01 : 2'b10);
        end
        last_ls = exp_ls;
        n_fair++;
      end
      if (p_if_ack || p_ls_ack) begin
        total++;
        if (p_ls_ack !== 1'b1 || p_if_ack !== 1'b0) begin
          bad++; $display("FAIL prio_grant: got %b want 01", {p_if_ack, p_ls_ack});
        end
      end
    end
    total++;
    if (n_fair != 4) begin
      bad++; $display("FAIL fair_count: got %0d want 4", n_fair);
    end
    ls_req = 1'b0;
    seen_if = 1'b0;
    cyc = 0;
    while (!seen_if && cyc < 10) begin
      @(negedge clk);
      cyc++;
      if (p_if_ack || p_ls_ack) begin
        seen_if = 1'b1;
        total++;
        if (p_if_ack !== 1'b1) begin
          bad++; $display("FAIL prio_after_drop: got %b want 10", {p_if_ack, p_ls_ack});
        end
      end
    end
    total++;
    if (!seen_if) begin
      bad++; $display("FAIL prio_if_timeout: got none want if_ack");
    end
    if_req = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid_access();
    bit any_ack;
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 16'h0010; ls_wdata = 16'hABCD;
    @(negedge clk);
    total++;
    if (mem_we !== 1'b1) begin
      bad++; $display("FAIL abort_we_before: got %b want 1", mem_we);
    end
    #1;
    reset = 1'b1; ls_req = 1'b0;
    #1;
    total++;
    if (mem_we !== 1'b0) begin
      bad++; $display("FAIL abort_we_async: got %b want 0", mem_we);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    total++;
    if ({if_ack, ls_ack, if_err, ls_err, mem_we, mem_a, mem_wd, if_data, ls_rdata} !== 69'h0) begin
      bad++; $display("FAIL abort_outputs: got %h want 0", {if_ack, ls_ack, if_err, ls_err, mem_we, mem_a, mem_wd, if_data, ls_rdata});
    end
    any_ack = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (if_ack || ls_ack || mem_we) any_ack = 1'b1;
    end
    total++;
    if (any_ack) begin
      bad++; $display("FAIL abort_quiet: got activity want none");
    end
    total++;
    if (mem[8] !== ref_mem[8]) begin
      bad++; $display("FAIL abort_mem8: got %h want %h", mem[8], ref_mem[8]);
    end
    do_access(1'b0, 1'b0, 16'h0010, 16'h0000, "post_abort_fetch");
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) ref_mem[i] = 16'($urandom);
    ref_mem[0] = 16'hF010;
    ref_mem[8] = 16'h1234;
    test_reset();
    test_fetch();
    test_store_load();
    test_misaligned();
    test_back_to_back();
    test_conflict();
    test_random();
    test_reset_mid_access();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
